// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter. A fetch port and a data port share one
// registered memory request port. Data normally wins a collision, but after
// FAIR_MAX consecutive data grants with a fetch waiting, the fetch goes next.
// Each grant waits at most TIMEOUT cycles for m_ack. After that it completes
// with zero read data and an err pulse.
module mem_port_arbiter #(
    parameter int TIMEOUT  = 64,
    parameter int FAIR_MAX = 4
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        err,
    output logic        stall_if,
    output logic        stall_d
);
    // Wait counter only has to reach TIMEOUT-1; streak has to reach FAIR_MAX.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SW = $clog2(FAIR_MAX + 1);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(FAIR_MAX);

    typedef enum logic [2:0] {IDLE, GNT_I, GNT_D, DONE_I, DONE_D} state_e;

    state_e        state_q;
    logic [CW-1:0] wait_q;
    logic [SW-1:0] streak_q;
    logic          m_req_q, m_we_q, if_ack_q, d_ack_q, err_q;
    logic [31:0]   m_addr_q, m_wdata_q, if_rdata_q, d_rdata_q;

    logic          streak_sat;
    logic          data_win_d;
    logic [SW-1:0] streak_d;

    // Arbitration decision and the streak value to load on a data grant.
    always_comb begin
        streak_sat = (streak_q == STREAK_MAX);
        data_win_d = d_req & (~streak_sat | ~if_req);
        streak_d   = '0;
        if (if_req)
            streak_d = streak_sat ? streak_q : streak_q + 1'b1;
    end

    // Arbiter FSM with all memory-side and ack outputs registered.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            streak_q   <= '0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            err_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (data_win_d) begin
                        state_q   <= GNT_D;
                        m_req_q   <= 1'b1;
                        m_we_q    <= d_we;
                        m_addr_q  <= d_addr;
                        m_wdata_q <= d_wdata;
                        wait_q    <= '0;
                        streak_q  <= streak_d;
                    end else if (if_req) begin
                        state_q   <= GNT_I;
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= if_addr;
                        m_wdata_q <= '0;
                        wait_q    <= '0;
                        streak_q  <= '0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (m_ack) begin
                        m_req_q <= 1'b0;
                        if (state_q == GNT_D) begin
                            state_q <= DONE_D;
                            d_ack_q <= 1'b1;
                            // A write leaves the last read data in place.
                            if (!m_we_q) d_rdata_q <= m_rdata;
                        end else begin
                            state_q    <= DONE_I;
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= m_rdata;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        // Give up: complete the requester with zero data and flag it.
                        m_req_q <= 1'b0;
                        err_q   <= 1'b1;
                        if (state_q == GNT_D) begin
                            state_q   <= DONE_D;
                            d_ack_q   <= 1'b1;
                            d_rdata_q <= '0;
                        end else begin
                            state_q    <= DONE_I;
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= '0;
                        end
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                // One ack cycle, then back to IDLE so the finishing requester
                // has dropped its request before arbitration runs again.
                DONE_I, DONE_D: state_q <= IDLE;
                default:        state_q <= IDLE;
            endcase
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign if_ack   = if_ack_q;
    assign d_ack    = d_ack_q;
    assign err      = err_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign stall_if = if_req & ~if_ack_q;
    assign stall_d  = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// random traffic, all checked against a transaction-level model of the
// requesters, the fairness rule and a memory.
module tb_mem_port_arbiter;
    localparam int TIMEOUT  = 64;
    localparam int FAIR_MAX = 4;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ack = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
    logic        if_ack, d_ack, m_req, m_we, err, stall_if, stall_d;

    always #5 cpu_clk = ~cpu_clk;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT), .FAIR_MAX(FAIR_MAX)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .err(err),
        .stall_if(stall_if), .stall_d(stall_d)
    );

    int nchk = 0;
    int nerr = 0;

    // Requester intent and the reference model state.
    bit          if_on, d_on, dwe_r;
    logic [31:0] ia, da, dw;
    logic [31:0] exp_if_rdata, exp_d_rdata;
    int          data_run;            // data grants in a row made while a fetch waited
    logic [31:0] mem [logic [31:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge cpu_clk);
    endtask

    task automatic drive();
        if_req  = if_on;
        if_addr = ia;
        d_req   = d_on;
        d_we    = dwe_r;
        d_addr  = da;
        d_wdata = dw;
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
        return a;
    endfunction

    // One complete transaction: wait for the grant, check it goes to the
    // requester the fairness rule picks, play memory for `lat` extra cycles
    // (lat >= TIMEOUT means never answer), then check the completion.
    task automatic do_xfer(input int lat, input int exp_wait, output bit obs_d, output int mcyc);
        bit          win_d, tout, acked;
        int          waited;
        logic [31:0] ea, rd;
        obs_d = 1'b0;
        mcyc  = 0;
        win_d = d_on && (data_run < FAIR_MAX || !if_on);
        ea    = win_d ? da : ia;
        rd    = mem_rd(ea);
        waited = 0;
        while (1) begin
            tick();
            waited++;
            if (m_req === 1'b1) break;
            chk("wait_stall_if", 32'(stall_if), 32'(if_on));
            chk("wait_stall_d", 32'(stall_d), 32'(d_on));
            if (waited > 8) begin
                chk("grant_never_came", 32'(m_req), 32'd1);
                return;
            end
        end
        if (exp_wait >= 0) chk("grant_latency", 32'(waited), 32'(exp_wait));
        if (win_d) data_run = if_on ? ((data_run < FAIR_MAX) ? data_run + 1 : FAIR_MAX) : 0;
        else       data_run = 0;
        acked = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            mcyc = k;
            chk("m_req_held", 32'(m_req), 32'd1);
            chk("m_addr", m_addr, ea);
            chk("m_we", 32'(m_we), 32'(win_d && dwe_r));
            if (win_d && dwe_r) chk("m_wdata", m_wdata, dw);
            chk("gnt_stall_if", 32'(stall_if), 32'(if_on));
            chk("gnt_stall_d", 32'(stall_d), 32'(d_on));
            chk("gnt_no_ack", 32'({if_ack, d_ack}), 32'd0);
            if (lat < TIMEOUT && k == lat + 1) begin
                m_ack   = 1'b1;
                m_rdata = rd;
                tick();
                acked = 1'b1;
                break;
            end
            m_rdata = $urandom;
            tick();
        end
        m_ack = 1'b0;
        tout  = !acked;
        obs_d = (d_ack === 1'b1);
        chk("done_m_req", 32'(m_req), 32'd0);
        chk("done_if_ack", 32'(if_ack), 32'(!win_d));
        chk("done_d_ack", 32'(d_ack), 32'(win_d));
        chk("done_err", 32'(err), 32'(tout));
        if (win_d) begin
            if (tout) exp_d_rdata = '0;
            else if (dwe_r) mem[da] = dw;
            else exp_d_rdata = rd;
        end else begin
            exp_if_rdata = tout ? 32'd0 : rd;
        end
        chk("done_if_rdata", if_rdata, exp_if_rdata);
        chk("done_d_rdata", d_rdata, exp_d_rdata);
        chk("done_stall_if", 32'(stall_if), 32'(if_on && win_d));
        chk("done_stall_d", 32'(stall_d), 32'(d_on && !win_d));
        if (win_d) d_on = 1'b0;
        else if_on = 1'b0;
        drive();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit od;
        int mc;
        if_on = 0; d_on = 0; dwe_r = 0; ia = '0; da = '0; dw = '0;
        exp_if_rdata = '0; exp_d_rdata = '0; data_run = 0;
        drive();

        // Reset state.
        #2 cpu_rst = 1'b0;
        tick();
        tick();
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_m_we", 32'(m_we), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_acks", 32'({if_ack, d_ack, err}), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_stalls", 32'({stall_if, stall_d}), 32'd0);

        // Fetch only, memory answers in the first grant cycle.
        cpu_rst = 1'b1;
        if_on = 1; ia = 32'h100;
        mem[32'h100] = 32'h0000_0013;
        drive();
        do_xfer(0, 1, od, mc);
        chk("fetch_mreq_cycles", 32'(mc), 32'd1);
        chk("fetch_rdata", if_rdata, 32'h0000_0013);

        // Simultaneous: data write wins, then the fetch.
        if_on = 1; ia = 32'h300;
        d_on = 1; dwe_r = 1; da = 32'h200; dw = 32'h0000_CAFE;
        drive();
        do_xfer(0, 2, od, mc);
        chk("both_first_is_data", 32'(od), 32'd1);
        do_xfer(1, 2, od, mc);
        chk("both_second_is_fetch", 32'(od), 32'd0);

        // Starvation bound: fetch waits while data keeps requesting.
        if_on = 1; ia = 32'h400;
        for (int g = 0; g < FAIR_MAX + 1; g++) begin
            if (!d_on) begin
                d_on = 1; dwe_r = 0; da = 32'h500 + 32'(g) * 4;
            end
            drive();
            do_xfer(0, 2, od, mc);
            chk($sformatf("starve_grant%0d_is_data", g), 32'(od), 32'(g < FAIR_MAX));
        end
        do_xfer(0, 2, od, mc);
        chk("starve_tail_is_data", 32'(od), 32'd1);

        // Timeout on a data read.
        d_on = 1; dwe_r = 0; da = 32'h600;
        exp_d_rdata = d_rdata;
        drive();
        do_xfer(TIMEOUT, 2, od, mc);
        chk("tout_mreq_cycles", 32'(mc), 32'(TIMEOUT));

        // Five-cycle memory latency; stall_d is checked every cycle inside.
        d_on = 1; dwe_r = 0; da = 32'h200;
        drive();
        do_xfer(4, 2, od, mc);
        chk("lat5_mreq_cycles", 32'(mc), 32'd5);
        chk("lat5_rdata", d_rdata, 32'h0000_CAFE);

        // m_ack with no grant outstanding is ignored.
        m_ack = 1'b1;
        m_rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stray_ack_quiet", 32'({m_req, if_ack, d_ack, err}), 32'd0);
        end
        m_ack = 1'b0;
        chk("stray_ack_rdata", d_rdata, exp_d_rdata);

        // Asynchronous reset in the middle of a fetch grant.
        if_on = 1; ia = 32'h700;
        drive();
        tick();
        chk("midrst_granted", 32'(m_req), 32'd1);
        #2 cpu_rst = 1'b0;
        #1 chk("midrst_m_req_async", 32'(m_req), 32'd0);
        chk("midrst_m_addr_async", m_addr, 32'd0);
        tick();
        chk("midrst_no_ack", 32'({if_ack, d_ack}), 32'd0);
        cpu_rst = 1'b1;
        exp_if_rdata = '0; exp_d_rdata = '0; data_run = 0;
        do_xfer(1, 1, od, mc);
        chk("midrst_regrant_fetch", 32'(od), 32'd0);

        // Random traffic against the model.
        for (int it = 0; it < 60; it++) begin
            if (!if_on && $urandom_range(0, 1) == 1) begin
                if_on = 1; ia = rand_addr();
            end
            if (!d_on && $urandom_range(0, 1) == 1) begin
                d_on = 1; dwe_r = $urandom_range(0, 1) == 1; da = rand_addr(); dw = $urandom;
            end
            if (!if_on && !d_on) begin
                d_on = 1; dwe_r = 0; da = rand_addr();
            end
            drive();
            begin
                int lat;
                lat = int'($urandom_range(0, 3));
                do_xfer(lat, 2, od, mc);
                chk("rand_mreq_cycles", 32'(mc), 32'(lat + 1));
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
